// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls D on unresolved register dependencies
// and on mult/div unit occupancy, and counts stall cycles since reset.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  D_rs_addr,
  input  logic [4:0]  D_rt_addr,
  input  logic [1:0]  D_Tuse_rs,
  input  logic [1:0]  D_Tuse_rt,
  input  logic        D_is_md,
  input  logic        E_Reg_WE,
  input  logic [4:0]  E_Reg_WA,
  input  logic [1:0]  E_Tnew,
  input  logic        M_Reg_WE,
  input  logic [4:0]  M_Reg_WA,
  input  logic [1:0]  M_Tnew,
  input  logic        E_md_start,
  input  logic        E_md_op,
  output logic        F_Reg_WE,
  output logic        D_Reg_WE,
  output logic        E_Reg_flush,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  logic        stall_rs;
  logic        stall_rt;
  logic        stall_md;
  logic        stall;
  logic [3:0]  md_cnt_q;
  logic [3:0]  md_cnt_d;
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // A source stalls only if a live writer targets it and will not have its
  // result ready by the time D needs it; Tuse=3 can never be below a 2-bit Tnew.
  function automatic logic raw_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic       we,
    input logic [4:0] wa,
    input logic [1:0] tnew
  );
    return (src != 5'd0) && we && (wa == src) && (tuse < tnew);
  endfunction

  always_comb begin
    stall_rs = raw_hazard(D_rs_addr, D_Tuse_rs, E_Reg_WE, E_Reg_WA, E_Tnew) |
               raw_hazard(D_rs_addr, D_Tuse_rs, M_Reg_WE, M_Reg_WA, M_Tnew);
    stall_rt = raw_hazard(D_rt_addr, D_Tuse_rt, E_Reg_WE, E_Reg_WA, E_Tnew) |
               raw_hazard(D_rt_addr, D_Tuse_rt, M_Reg_WE, M_Reg_WA, M_Tnew);
    stall_md = D_is_md && (E_md_start || (md_cnt_q != 4'd0));
    stall    = stall_rs | stall_rt | stall_md;
  end

  // A start while the unit is still counting is dropped, not queued.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_cnt_q != 4'd0) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end else if (E_md_start) begin
      md_cnt_d = E_md_op ? DIV_CYCLES : MULT_CYCLES;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      md_cnt_q    <= 4'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign F_Reg_WE    = ~stall;
  assign D_Reg_WE    = ~stall;
  assign E_Reg_flush = stall;
  assign md_busy     = (md_cnt_q != 4'd0);
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios then random traffic, checked
// against a cycle-indexed reference model of stall and busy behaviour.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  D_rs_addr, D_rt_addr;
  logic [1:0]  D_Tuse_rs, D_Tuse_rt;
  logic        D_is_md;
  logic        E_Reg_WE;
  logic [4:0]  E_Reg_WA;
  logic [1:0]  E_Tnew;
  logic        M_Reg_WE;
  logic [4:0]  M_Reg_WA;
  logic [1:0]  M_Tnew;
  logic        E_md_start, E_md_op;
  logic        F_Reg_WE, D_Reg_WE, E_Reg_flush, md_busy;
  logic [31:0] stall_cnt;

  int          checks = 0;
  int          passed = 0;

  // Model: the unit is busy while the cycle number is below busy_end.
  longint      cyc = 0;
  longint      busy_end = 0;
  logic [31:0] exp_cnt = 32'd0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .D_rs_addr   (D_rs_addr),
    .D_rt_addr   (D_rt_addr),
    .D_Tuse_rs   (D_Tuse_rs),
    .D_Tuse_rt   (D_Tuse_rt),
    .D_is_md     (D_is_md),
    .E_Reg_WE    (E_Reg_WE),
    .E_Reg_WA    (E_Reg_WA),
    .E_Tnew      (E_Tnew),
    .M_Reg_WE    (M_Reg_WE),
    .M_Reg_WA    (M_Reg_WA),
    .M_Tnew      (M_Tnew),
    .E_md_start  (E_md_start),
    .E_md_op     (E_md_op),
    .F_Reg_WE    (F_Reg_WE),
    .D_Reg_WE    (D_Reg_WE),
    .E_Reg_flush (E_Reg_flush),
    .md_busy     (md_busy),
    .stall_cnt   (stall_cnt)
  );

  function automatic logic dep(input logic [4:0] src, input logic [1:0] tuse,
                               input logic we, input logic [4:0] wa,
                               input logic [1:0] tnew);
    return (src != 5'd0) && we && (wa == src) && (int'(tuse) < int'(tnew));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, cyc);
  endtask

  task automatic idle_inputs();
    rst = 1'b0;
    D_rs_addr = 5'd0; D_rt_addr = 5'd0; D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3;
    D_is_md = 1'b0;
    E_Reg_WE = 1'b0; E_Reg_WA = 5'd0; E_Tnew = 2'd0;
    M_Reg_WE = 1'b0; M_Reg_WA = 5'd0; M_Tnew = 2'd0;
    E_md_start = 1'b0; E_md_op = 1'b0;
  endtask

  // Check the current cycle against the model, then advance one clock.
  task automatic cycle();
    logic exp_busy, exp_stall;
    #1;
    exp_busy  = (cyc < busy_end);
    exp_stall = dep(D_rs_addr, D_Tuse_rs, E_Reg_WE, E_Reg_WA, E_Tnew) ||
                dep(D_rs_addr, D_Tuse_rs, M_Reg_WE, M_Reg_WA, M_Tnew) ||
                dep(D_rt_addr, D_Tuse_rt, E_Reg_WE, E_Reg_WA, E_Tnew) ||
                dep(D_rt_addr, D_Tuse_rt, M_Reg_WE, M_Reg_WA, M_Tnew) ||
                (D_is_md && (E_md_start || exp_busy));
    chk("F_Reg_WE", {31'd0, F_Reg_WE}, {31'd0, !exp_stall});
    chk("D_Reg_WE", {31'd0, D_Reg_WE}, {31'd0, !exp_stall});
    chk("E_Reg_flush", {31'd0, E_Reg_flush}, {31'd0, exp_stall});
    chk("md_busy", {31'd0, md_busy}, {31'd0, exp_busy});
    chk("stall_cnt", stall_cnt, exp_cnt);
    @(posedge clk);
    if (rst) begin
      busy_end = 0;
      exp_cnt  = 32'd0;
    end else begin
      if (exp_stall && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
      if (E_md_start && !exp_busy) busy_end = cyc + 1 + (E_md_op ? 10 : 5);
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    chk("reset_busy", {31'd0, md_busy}, 32'd0);
    chk("reset_cnt", stall_cnt, 32'd0);
    cycle();

    // load-use on rs from E
    E_Reg_WE = 1'b1; E_Reg_WA = 5'd8; E_Tnew = 2'd2;
    D_rs_addr = 5'd8; D_Tuse_rs = 2'd1;
    #1;
    chk("loaduse_F", {31'd0, F_Reg_WE}, 32'd0);
    chk("loaduse_flush", {31'd0, E_Reg_flush}, 32'd1);
    cycle();
    idle_inputs();
    #1;
    chk("loaduse_cnt", stall_cnt, 32'd1);
    cycle();

    // no-stall variants
    E_Reg_WE = 1'b1; E_Reg_WA = 5'd0; E_Tnew = 2'd2; D_rs_addr = 5'd0; D_Tuse_rs = 2'd1;
    #1; chk("reg0_F", {31'd0, F_Reg_WE}, 32'd1);
    cycle();
    E_Reg_WA = 5'd8; D_rs_addr = 5'd8; D_Tuse_rs = 2'd3;
    #1; chk("tuse3_flush", {31'd0, E_Reg_flush}, 32'd0);
    cycle();
    idle_inputs();
    M_Reg_WE = 1'b1; M_Reg_WA = 5'd8; M_Tnew = 2'd0; D_rs_addr = 5'd8; D_Tuse_rs = 2'd0;
    #1; chk("mtnew0_F", {31'd0, F_Reg_WE}, 32'd1);
    cycle();
    // rt dependency through M
    idle_inputs();
    M_Reg_WE = 1'b1; M_Reg_WA = 5'd9; M_Tnew = 2'd2; D_rt_addr = 5'd9; D_Tuse_rt = 2'd0;
    #1; chk("rt_m_flush", {31'd0, E_Reg_flush}, 32'd1);
    cycle();

    // mult with an md instruction waiting in D
    idle_inputs();
    D_is_md = 1'b1; E_md_start = 1'b1; E_md_op = 1'b0;
    for (int k = 0; k <= 7; k++) begin
      if (k == 1) E_md_start = 1'b0;
      #1;
      chk("mult_stall", {31'd0, E_Reg_flush}, {31'd0, (k <= 5)});
      cycle();
    end

    // div with a redundant start at t+3
    idle_inputs();
    E_md_start = 1'b1; E_md_op = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      E_md_start = (k == 0 || k == 3);
      #1;
      chk("div_busy", {31'd0, md_busy}, {31'd0, (k >= 1 && k <= 10)});
      cycle();
    end

    // reset in the middle of a div, then a new mult is accepted
    idle_inputs();
    E_md_start = 1'b1; E_md_op = 1'b1;
    for (int k = 0; k <= 11; k++) begin
      E_md_start = (k == 0 || k == 5);
      E_md_op    = (k == 0);
      rst        = (k == 4);
      #1;
      if (k == 5) begin
        chk("rstmid_busy", {31'd0, md_busy}, 32'd0);
        chk("rstmid_cnt", stall_cnt, 32'd0);
      end
      if (k >= 6) chk("rstmid_mult", {31'd0, md_busy}, {31'd0, (k <= 10)});
      cycle();
    end

    // saturation
    idle_inputs();
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    exp_cnt = 32'hFFFF_FFFE;
    E_Reg_WE = 1'b1; E_Reg_WA = 5'd8; E_Tnew = 2'd2; D_rs_addr = 5'd8; D_Tuse_rs = 2'd1;
    cycle(); cycle(); cycle();
    idle_inputs();
    #1;
    chk("saturate", stall_cnt, 32'hFFFF_FFFF);
    cycle();

    // random traffic
    for (int k = 0; k < 400; k++) begin
      rst        = ($urandom_range(0, 63) == 0);
      D_rs_addr  = 5'($urandom_range(0, 3));
      D_rt_addr  = 5'($urandom_range(0, 3));
      D_Tuse_rs  = 2'($urandom_range(0, 3));
      D_Tuse_rt  = 2'($urandom_range(0, 3));
      D_is_md    = ($urandom_range(0, 3) == 0);
      E_Reg_WE   = 1'($urandom);
      E_Reg_WA   = 5'($urandom_range(0, 3));
      E_Tnew     = 2'($urandom);
      M_Reg_WE   = 1'($urandom);
      M_Reg_WA   = 5'($urandom_range(0, 3));
      M_Tnew     = 2'($urandom);
      E_md_start = ($urandom_range(0, 5) == 0);
      E_md_op    = 1'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state updates on posedge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: D_rs_addr, D_rt_addr  in  5 each  source registers of the instruction in D.
REQ-004 SHALL have ports: D_Tuse_rs, D_Tuse_rt  in  2 each  cycles until D needs the operand; 3 means operand unused.
REQ-005 SHALL have ports: D_is_md  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-006 SHALL have ports: E_Reg_WE  in  1, E_Reg_WA  in  5, E_Tnew  in  2  writer in E and cycles until its result exists.
REQ-007 SHALL have ports: M_Reg_WE  in  1, M_Reg_WA  in  5, M_Tnew  in  2  same for M.
REQ-008 SHALL have ports: E_md_start  in  1  mult/div issues in E this cycle; E_md_op  in  1  0=mult, 1=div.
REQ-009 SHALL have ports: F_Reg_WE, D_Reg_WE  out  1  enables of PC and F/D register; E_Reg_flush  out  1  loads a bubble into D/E.
REQ-010 SHALL have ports: md_busy  out  1  multiply/divide unit occupied; stall_cnt  out  32  stall cycles since reset.

Function
REQ-011 SHALL assert stall_rs when D_rs_addr!=0 and D_Tuse_rs<E_Tnew and E_Reg_WE and E_Reg_WA==D_rs_addr.
REQ-012 SHALL also assert stall_rs under the REQ-011 conditions with M_Reg_WE, M_Reg_WA, M_Tnew in place of the E signals.
REQ-013 SHALL compute stall_rt identically from D_rt_addr and D_Tuse_rt.
REQ-014 SHALL never stall on register 0; D_Tuse=3 SHALL never stall, since the comparison cannot hold for 2-bit Tnew.
REQ-015 SHALL hold a 4-bit busy counter cnt; on E_md_start with cnt==0, load cnt=5 for mult or cnt=10 for div.
REQ-016 SHALL decrement cnt by 1 each cycle while cnt!=0 and stop at 0 without wrap.
REQ-017 SHALL ignore E_md_start while cnt!=0; no reload and no error.
REQ-018 SHALL drive md_busy = (cnt!=0), combinational from the register.
REQ-019 SHALL assert stall_md when D_is_md and (E_md_start or cnt!=0).
REQ-020 SHALL compute stall = stall_rs | stall_rt | stall_md, combinational, zero-latency in the same cycle.
REQ-021 SHALL drive F_Reg_WE = D_Reg_WE = ~stall and E_Reg_flush = stall.
REQ-022 SHALL increment stall_cnt by 1 on each posedge where stall=1 and rst=0, saturating at 0xFFFFFFFF.
REQ-023 SHALL yield busy duration: mult issued at cycle t gives md_busy=1 in cycles t+1..t+5 and 0 at t+6; div gives 1 in cycles t+1..t+10.
REQ-024 SHALL derive no output from a clock edge other than posedge clk, and SHALL contain no latches.

Reset
REQ-025 SHALL set cnt=0 and stall_cnt=0 on a posedge with rst=1.
REQ-026 SHALL give precedence to rst over E_md_start and over stall counting.
REQ-027 SHALL, on reset mid-operation (cnt!=0), read md_busy=0 in the cycle after the reset edge.
REQ-028 SHALL keep the combinational stall outputs input-driven during reset; the pipeline registers' own rst clears them.

Verification
REQ-029 SHALL cover load-use: E_Reg_WE=1, E_Reg_WA=8, E_Tnew=2, D_rs_addr=8, D_Tuse_rs=1 -> F_Reg_WE=0, D_Reg_WE=0, E_Reg_flush=1, stall_cnt +1.
REQ-030 SHALL cover the no-stall cases: as REQ-029 with D_rs_addr=0, or D_Tuse_rs=3, or M_Tnew=0 match in M -> F_Reg_WE=1, E_Reg_flush=0.
REQ-031 SHALL cover mult: E_md_start=1, E_md_op=0 at cycle t, D_is_md=1 throughout -> stall in cycles t..t+5, released at t+6.
REQ-032 SHALL cover div plus redundant start: div at t and E_md_start again at t+3 -> md_busy falls at t+11, not later.
REQ-033 SHALL cover reset mid-div: rst=1 at t+4 of a div -> md_busy=0 and stall_cnt=0 at t+5, and a new mult is accepted at t+5.
REQ-034 SHALL cover saturation: stall_cnt forced to 0xFFFFFFFE, then 3 stall cycles -> stall_cnt=0xFFFFFFFF.
